// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting single-word read/write access to a bank of
// enable-loaded registers; one transaction per IDLE -> GRANT -> ACK pass.
module reg_bank_cell #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         a_reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) q <= '0;
        else if (load)  q <= d;
    end
endmodule

module reg_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_REGS    = 4,
    parameter int REG_WIDTH = 8,
    parameter int ADDR_W    = 2
) (
    input  logic                        clk,
    input  logic                        a_reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ*ADDR_W-1:0]     addr,
    input  logic [N_REQ*REG_WIDTH-1:0]  wdata,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            ack,
    output logic [REG_WIDTH-1:0]        rdata,
    output logic                        busy,
    output logic [N_REGS-1:0]           reg_upd
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]                         state;
    logic [IDX_W-1:0]                   ptr;
    logic [IDX_W-1:0]                   sel;
    logic                               sel_vld;
    logic [N_REQ-1:0]                   sel_oh;
    logic                               cur_we;
    logic [ADDR_W-1:0]                  cur_addr;
    logic [REG_WIDTH-1:0]               cur_wdata;
    logic [N_REGS-1:0][REG_WIDTH-1:0]   bank;
    logic [N_REGS-1:0]                  addr_oh;
    logic                               wr_go;

    // First set request at or after ptr, wrapping; the winner moves ptr past itself.
    always_comb begin
        int idx;
        idx     = 0;
        sel_vld = 1'b0;
        sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!sel_vld && req[idx]) begin
                sel_vld = 1'b1;
                sel     = IDX_W'(idx);
            end
        end
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    always_comb begin
        addr_oh           = '0;
        addr_oh[cur_addr] = 1'b1;
    end

    assign wr_go = (state == S_GRANT) && cur_we;

    for (genvar k = 0; k < N_REGS; k++) begin : g_reg
        reg_bank_cell #(.W(REG_WIDTH)) u_cell (
            .clk       (clk),
            .a_reset_n (a_reset_n),
            .load      (wr_go && addr_oh[k]),
            .d         (cur_wdata),
            .q         (bank[k])
        );
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            grant     <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            reg_upd   <= '0;
        end else begin
            ack     <= '0;
            reg_upd <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        // Requester inputs are captured only here; later changes are ignored.
                        grant     <= sel_oh;
                        cur_we    <= we[sel];
                        cur_addr  <= addr[int'(sel)*ADDR_W +: ADDR_W];
                        cur_wdata <= wdata[int'(sel)*REG_WIDTH +: REG_WIDTH];
                        ptr       <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + 1'b1;
                        busy      <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (cur_we) reg_upd <= addr_oh;
                    else        rdata   <= bank[cur_addr];
                    ack   <= grant;
                    state <= S_ACK;
                end
                S_ACK: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: expected completions are queued as requests
// are driven and checked against each ack as it appears.
module tb_reg_bank_arbiter;
    localparam int N_REQ = 4, N_REGS = 4, RW = 8, AW = 2;

    logic                 clk = 1'b0;
    logic                 a_reset_n = 1'b0;
    logic [N_REQ-1:0]     req = '0;
    logic [N_REQ-1:0]     we = '0;
    logic [N_REQ*AW-1:0]  addr = '0;
    logic [N_REQ*RW-1:0]  wdata = '0;
    logic [N_REQ-1:0]     grant, ack;
    logic [RW-1:0]        rdata;
    logic                 busy;
    logic [N_REGS-1:0]    reg_upd;

    typedef struct {
        int         who;
        logic       is_wr;
        int         a;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, passes = 0, cyc = 0, last_ack_cyc = -1;

    reg_bank_arbiter #(.N_REQ(N_REQ), .N_REGS(N_REGS), .REG_WIDTH(RW), .ADDR_W(AW)) dut (
        .clk(clk), .a_reset_n(a_reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .grant(grant), .ack(ack), .rdata(rdata), .busy(busy), .reg_upd(reg_upd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_rdata"}, 32'(rdata), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_reg_upd"}, 32'(reg_upd), 0);
    endtask

    // Drive one requester; exp_data is the read value expected (ignored for writes).
    task automatic issue(input int who, input logic w, input int a, input logic [7:0] d,
                         input logic [7:0] exp_data, input bit push);
        exp_t e;
        req[who]          = 1'b1;
        we[who]           = w;
        addr[who*AW +: AW] = AW'(a);
        wdata[who*RW +: RW] = d;
        e.who = who; e.is_wr = w; e.a = a; e.data = w ? d : exp_data;
        if (push) sb.push_back(e);
    endtask

    // Wait for n acks, compare each with the scoreboard head; optionally drop the owner's req.
    task automatic collect(input int n, input bit drop, input bit chk_gap);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            int t = 0;
            do begin @(negedge clk); t++; end while (ack === '0 && t < 20);
            chk("ack_wait", 32'(t < 20), 1);
            if (t >= 20) return;
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() == 0) return;
            e = sb.pop_front();
            chk($sformatf("ack_who%0d", e.who), 32'(ack), 32'(1) << e.who);
            chk("grant_held", 32'(grant), 32'(1) << e.who);
            if (e.is_wr) chk("reg_upd", 32'(reg_upd), 32'(1) << e.a);
            else begin
                chk("rdata", 32'(rdata), 32'(e.data));
                chk("reg_upd_rd", 32'(reg_upd), 0);
            end
            if (chk_gap && last_ack_cyc >= 0) chk("ack_gap", 32'(cyc - last_ack_cyc), 3);
            last_ack_cyc = cyc;
            if (drop) req[e.who] = 1'b0;
        end
    endtask

    initial begin
        // Test 1/3: reset state, then all four reading continuously.
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        a_reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) issue(i, 1'b0, i, 8'h00, 8'h00, 1'b1);
        issue(0, 1'b0, 0, 8'h00, 8'h00, 1'b1);
        collect(5, 1'b0, 1'b1);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_rr", 32'({busy, grant}), 0);

        // Test 2: single write from req0, exact timing (ptr=1 here, req0 still wins alone).
        issue(0, 1'b1, 2, 8'hA5, 8'h00, 1'b0);
        @(negedge clk);
        chk("t2_grant", 32'(grant), 32'b0001);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_no_ack_yet", 32'(ack), 0);
        @(negedge clk);
        chk("t2_ack", 32'(ack), 32'b0001);
        chk("t2_reg_upd", 32'(reg_upd), 32'b0100);
        chk("t2_rdata_unchanged", 32'(rdata), 0);
        req = '0;
        @(negedge clk);
        chk("t2_ack_pulse", 32'(ack), 0);
        chk("t2_reg_upd_pulse", 32'(reg_upd), 0);
        issue(2, 1'b0, 2, 8'h00, 8'hA5, 1'b1);
        collect(1, 1'b1, 1'b0);

        // Test 4: req1 moves ptr to 2, then req1/req3 contend for addr1.
        issue(1, 1'b1, 3, 8'h5A, 8'h00, 1'b1);
        collect(1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        issue(3, 1'b1, 1, 8'hC3, 8'h00, 1'b1);
        issue(1, 1'b1, 1, 8'h3C, 8'h00, 1'b1);
        @(negedge clk);
        chk("t4_single_owner", 32'(grant), 32'b1000);
        collect(2, 1'b1, 1'b0);
        chk("t4_rdata_held", 32'(rdata), 32'hA5);
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 1, 8'h00, 8'h3C, 1'b1);
        collect(1, 1'b1, 1'b0);
        issue(2, 1'b0, 3, 8'h00, 8'h5A, 1'b1);
        collect(1, 1'b1, 1'b0);

        // Test 6: wdata changes while in GRANT; the captured value must land.
        repeat (2) @(negedge clk);
        issue(0, 1'b1, 0, 8'h11, 8'h00, 1'b1);
        @(negedge clk);
        wdata[0 +: RW] = 8'h22;
        collect(1, 1'b1, 1'b0);
        issue(2, 1'b0, 0, 8'h00, 8'h11, 1'b1);
        collect(1, 1'b1, 1'b0);

        // Test 5: reset during GRANT of a write aborts it.
        repeat (2) @(negedge clk);
        issue(1, 1'b1, 0, 8'hFF, 8'h00, 1'b0);
        @(negedge clk);
        chk("t5_in_grant", 32'(grant), 32'b0010);
        a_reset_n = 1'b0;
        #1;
        chk_idle_outputs("t5_async");
        req = '0;
        @(negedge clk);
        a_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_ack", 32'(ack), 0);
        end
        issue(3, 1'b0, 3, 8'h00, 8'h00, 1'b0);
        issue(0, 1'b0, 0, 8'h00, 8'h00, 1'b0);
        sb.push_back('{0, 1'b0, 0, 8'h00});
        sb.push_back('{3, 1'b0, 3, 8'h00});
        @(negedge clk);
        chk("t5_ptr_reset", 32'(grant), 32'b0001);
        collect(2, 1'b1, 1'b0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
